mem_addr_sel: RTL and testbench

Parametrised memory-address source selector and access sequencer for the multicycle datapath. It picks one of NUM_SRC address sources: PC, ALU result, ALUOut, exception vector, register A, and so on. It checks the selection and alignment, registers the chosen address, and holds it stable while it runs a req/ack access to memory. It reports completion, and reports faults with a cause code so the control unit can branch to exception handling.

---
 rtl/mem_addr_pkg.sv | 21 ++
 rtl/mem_align_chk.sv | 19 +
 rtl/mem_addr_sel.sv | 181 ++++++++++++++++++
 tb/tb_mem_addr_sel.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_addr_pkg.sv
// Shared encodings for the memory-address selector and the alignment checker:
// access sizes, fault cause codes and the sequencer state encoding.
package mem_addr_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISALIGN = 2'b01;
   localparam logic [1:0] FC_BAD_SEL  = 2'b10;
   localparam logic [1:0] FC_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2,
      ST_FAULT  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_align_chk.sv
// Combinational natural-alignment check for byte/half/word accesses.
// Shared with the load/store unit; size 11 is treated as a word access.
module mem_align_chk
   import mem_addr_pkg::*;
(
   input  logic [1:0] i_addr_lo,
   input  logic [1:0] i_size,
   output logic       o_misaligned
);

   always_comb begin
      case (i_size)
         SZ_BYTE: o_misaligned = 1'b0;
         SZ_HALF: o_misaligned = i_addr_lo[0];
         default: o_misaligned = |i_addr_lo;
      endcase
   end

endmodule

// File: rtl/mem_addr_sel.sv
// Memory-address source selector and req/ack access sequencer.
// Optional macro MEM_TIMEOUT_EN builds the ACCESS wait counter and timeout fault.
module mem_addr_sel
   import mem_addr_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int NUM_SRC  = 5,
   parameter int SEL_W    = $clog2(NUM_SRC),
   parameter int WAIT_MAX = 7
)
(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
   input  logic [SEL_W-1:0]          sel,
   input  logic [1:0]                size,
   input  logic                      wr,
   input  logic                      req,
   input  logic                      mem_ack,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_req,
   output logic                      mem_wr,
   output logic                      done,
   output logic                      fault,
   output logic [1:0]                fault_cause,
   output logic [ADDR_W-1:0]         fault_addr
);

   if (NUM_SRC < 2) begin : g_chk_num_src
      $error("mem_addr_sel: NUM_SRC must be at least 2");
   end
   if (WAIT_MAX < 1) begin : g_chk_wait_max
      $error("mem_addr_sel: WAIT_MAX must be at least 1");
   end

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_mem_addr;
   logic                r_mem_req;
   logic                r_mem_wr;
   logic                r_done;
   logic                r_fault;
   logic [1:0]          r_fault_cause;
   logic [ADDR_W-1:0]   r_fault_addr;

   logic [ADDR_W-1:0]   w_mem_addr_nxt;
   logic                w_mem_wr_nxt;
   logic [1:0]          w_fault_cause_nxt;
   logic [ADDR_W-1:0]   w_fault_addr_nxt;

   logic [ADDR_W-1:0]   w_sel_addr;
   logic                w_bad_sel;
   logic                w_misaligned;
   logic                w_start;
   logic                w_timeout;

   // Out-of-range selects leave w_sel_addr at zero; w_bad_sel flags them.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_sel_addr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == SEL_W'(i)) begin
            w_sel_addr = src_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign w_bad_sel = ({1'b0, sel} >= (SEL_W+1)'(NUM_SRC));
   assign w_start   = (r_state == ST_IDLE) && req;

   mem_align_chk u_align_chk (
      .i_addr_lo    (w_sel_addr[1:0]),
      .i_size       (size),
      .o_misaligned (w_misaligned)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(WAIT_MAX + 1);

   logic [CNT_W-1:0] r_wait_cnt;

   // Cleared while idle so every access starts counting from zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wait_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
         r_wait_cnt <= '0;
      end else if ((r_state == ST_ACCESS) && !mem_ack) begin
         r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
   end

   assign w_timeout = (r_wait_cnt == CNT_W'(WAIT_MAX - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req) begin
               w_state_nxt = (w_bad_sel || w_misaligned) ? ST_FAULT : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (mem_ack) begin
               w_state_nxt = ST_RESP;
            end else if (w_timeout) begin
               w_state_nxt = ST_FAULT;
            end
         end
         ST_RESP:  w_state_nxt = ST_IDLE;
         ST_FAULT: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Next values for the registered outputs; bad_sel outranks misalignment,
   // and an ack on the last wait cycle suppresses the timeout.
   always_comb begin
      w_mem_addr_nxt    = r_mem_addr;
      w_mem_wr_nxt      = r_mem_wr;
      w_fault_cause_nxt = r_fault_cause;
      w_fault_addr_nxt  = r_fault_addr;
      if (w_start) begin
         if (w_bad_sel) begin
            w_fault_cause_nxt = FC_BAD_SEL;
            w_fault_addr_nxt  = '0;
         end else if (w_misaligned) begin
            w_fault_cause_nxt = FC_MISALIGN;
            w_fault_addr_nxt  = w_sel_addr;
         end else begin
            w_mem_addr_nxt = w_sel_addr;
            w_mem_wr_nxt   = wr;
         end
      end else if ((r_state == ST_ACCESS) && !mem_ack && w_timeout) begin
         w_fault_cause_nxt = FC_TIMEOUT;
         w_fault_addr_nxt  = r_mem_addr;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem_addr    <= '0;
         r_mem_req     <= 1'b0;
         r_mem_wr      <= 1'b0;
         r_done        <= 1'b0;
         r_fault       <= 1'b0;
         r_fault_cause <= FC_NONE;
         r_fault_addr  <= '0;
      end else begin
         r_mem_addr    <= w_mem_addr_nxt;
         r_mem_req     <= (w_state_nxt == ST_ACCESS);
         r_mem_wr      <= w_mem_wr_nxt;
         r_done        <= (w_state_nxt == ST_RESP);
         r_fault       <= (w_state_nxt == ST_FAULT);
         r_fault_cause <= w_fault_cause_nxt;
         r_fault_addr  <= w_fault_addr_nxt;
      end
   end

   assign mem_addr    = r_mem_addr;
   assign mem_req     = r_mem_req;
   assign mem_wr      = r_mem_wr;
   assign done        = r_done;
   assign fault       = r_fault;
   assign fault_cause = r_fault_cause;
   assign fault_addr  = r_fault_addr;

endmodule

// File: tb/tb_mem_addr_sel.sv
// Directed self-checking bench for mem_addr_sel (NUM_SRC=5, WAIT_MAX=7).
// Timeout scenarios follow MEM_TIMEOUT_EN; without it ACCESS must wait for ack.
module tb_mem_addr_sel;
   import mem_addr_pkg::*;

   localparam int ADDR_W   = 32;
   localparam int NUM_SRC  = 5;
   localparam int SEL_W    = 3;
   localparam int WAIT_MAX = 7;

   logic                      clk;
   logic                      reset_n;
   logic [NUM_SRC*ADDR_W-1:0] src_addr;
   logic [SEL_W-1:0]          sel;
   logic [1:0]                size;
   logic                      wr;
   logic                      req;
   logic                      mem_ack;
   logic [ADDR_W-1:0]         mem_addr;
   logic                      mem_req;
   logic                      mem_wr;
   logic                      done;
   logic                      fault;
   logic [1:0]                fault_cause;
   logic [ADDR_W-1:0]         fault_addr;

   int errors = 0;
   int checks = 0;

   mem_addr_sel #(
      .ADDR_W   (ADDR_W),
      .NUM_SRC  (NUM_SRC),
      .SEL_W    (SEL_W),
      .WAIT_MAX (WAIT_MAX)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .src_addr    (src_addr),
      .sel         (sel),
      .size        (size),
      .wr          (wr),
      .req         (req),
      .mem_ack     (mem_ack),
      .mem_addr    (mem_addr),
      .mem_req     (mem_req),
      .mem_wr      (mem_wr),
      .done        (done),
      .fault       (fault),
      .fault_cause (fault_cause),
      .fault_addr  (fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are observed 1 time unit after the rising edge; inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int idx, input logic [ADDR_W-1:0] val);
      src_addr[idx*ADDR_W +: ADDR_W] = val;
   endtask

   // Holds req for the current cycle; returns in the cycle after req was sampled.
   task automatic start(input logic [SEL_W-1:0] s, input logic [1:0] sz, input logic w);
      sel  = s;
      size = sz;
      wr   = w;
      req  = 1'b1;
      tick();
      req  = 1'b0;
   endtask

   task automatic test_reset();
      reset_n  = 1'b1;
      src_addr = '0;
      sel      = '0;
      size     = SZ_WORD;
      wr       = 1'b0;
      req      = 1'b0;
      mem_ack  = 1'b0;
      #2 reset_n = 1'b0;
      repeat (2) tick();
      checks++;
      if ({mem_req, done, fault, mem_wr, fault_cause, mem_addr, fault_addr} !== '0) begin
         errors++;
         $display("FAIL reset_hold: req/done/fault/wr/cause=%b%b%b%b/%b addr=%h faddr=%h expected all zero",
                  mem_req, done, fault, mem_wr, fault_cause, mem_addr, fault_addr);
      end
      reset_n = 1'b1;
      tick();
      checks++;
      if ({mem_req, done, fault, fault_cause, mem_addr} !== '0) begin
         errors++;
         $display("FAIL reset_release: req/done/fault=%b%b%b cause=%b addr=%h expected zero",
                  mem_req, done, fault, fault_cause, mem_addr);
      end
   endtask

   // Word load from source 2, ack in cycle 3: mem_req cycles 1-3, done only in cycle 4.
   task automatic test_normal();
      logic [2:0] exp_ctl;
      set_src(0, 32'h0000_2000);
      set_src(1, 32'h0000_1002);
      set_src(2, 32'h0000_1004);
      set_src(3, 32'h0000_3000);
      set_src(4, 32'h0000_1003);
      start(3'd2, SZ_WORD, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         exp_ctl = (c <= 3) ? 3'b100 : (c == 4) ? 3'b010 : 3'b000;
         checks++;
         if ({mem_req, done, fault} !== exp_ctl || mem_addr !== 32'h0000_1004 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL normal_c%0d: req/done/fault=%b addr=%h wr=%b expected %b addr=00001004 wr=0",
                     c, {mem_req, done, fault}, mem_addr, mem_wr, exp_ctl);
         end
         mem_ack = (c == 3);
         tick();
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_align();
      start(3'd1, SZ_WORD, 1'b0);
      checks++;
      if ({mem_req, done, fault} !== 3'b001 || fault_cause !== FC_MISALIGN ||
          fault_addr !== 32'h0000_1002 || mem_addr !== 32'h0000_1004) begin
         errors++;
         $display("FAIL align_word: req/done/fault=%b cause=%b faddr=%h addr=%h expected 001 01 00001002 00001004",
                  {mem_req, done, fault}, fault_cause, fault_addr, mem_addr);
      end
      tick();
      checks++;
      if ({mem_req, done, fault} !== 3'b000 || fault_cause !== FC_MISALIGN || fault_addr !== 32'h0000_1002) begin
         errors++;
         $display("FAIL align_hold: req/done/fault=%b cause=%b faddr=%h expected 000 01 00001002",
                  {mem_req, done, fault}, fault_cause, fault_addr);
      end
      start(3'd1, SZ_HALF, 1'b1);
      checks++;
      if ({mem_req, done, fault} !== 3'b100 || mem_addr !== 32'h0000_1002 || mem_wr !== 1'b1) begin
         errors++;
         $display("FAIL align_half: req/done/fault=%b addr=%h wr=%b expected 100 00001002 1",
                  {mem_req, done, fault}, mem_addr, mem_wr);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, done, fault} !== 3'b010) begin
         errors++;
         $display("FAIL align_half_done: req/done/fault=%b expected 010", {mem_req, done, fault});
      end
      tick();
      start(3'd4, SZ_BYTE, 1'b0);
      checks++;
      if ({mem_req, done, fault} !== 3'b100 || mem_addr !== 32'h0000_1003) begin
         errors++;
         $display("FAIL align_byte_odd: req/done/fault=%b addr=%h expected 100 00001003",
                  {mem_req, done, fault}, mem_addr);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
   endtask

   task automatic test_bad_sel();
      logic [SEL_W-1:0] bad_sels [3] = '{3'd5, 3'd6, 3'd7};
      for (int k = 0; k < 3; k++) begin
         start(bad_sels[k], (k == 2) ? SZ_HALF : SZ_WORD, 1'b0);
         checks++;
         if ({mem_req, done, fault} !== 3'b001 || fault_cause !== FC_BAD_SEL || fault_addr !== '0) begin
            errors++;
            $display("FAIL bad_sel_%0d: req/done/fault=%b cause=%b faddr=%h expected 001 10 00000000",
                     bad_sels[k], {mem_req, done, fault}, fault_cause, fault_addr);
         end
         tick();
         checks++;
         if ({mem_req, done, fault} !== 3'b000) begin
            errors++;
            $display("FAIL bad_sel_%0d_after: req/done/fault=%b expected 000", bad_sels[k], {mem_req, done, fault});
         end
      end
      // Size 11 is a word access, so 0x1002 misaligns and overwrites the held cause.
      start(3'd1, 2'b11, 1'b0);
      checks++;
      if ({mem_req, done, fault} !== 3'b001 || fault_cause !== FC_MISALIGN || fault_addr !== 32'h0000_1002) begin
         errors++;
         $display("FAIL size11_misalign: req/done/fault=%b cause=%b faddr=%h expected 001 01 00001002",
                  {mem_req, done, fault}, fault_cause, fault_addr);
      end
      tick();
   endtask

   task automatic test_timeout();
      logic [2:0] exp_ctl;
`ifdef MEM_TIMEOUT_EN
      start(3'd0, SZ_WORD, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         exp_ctl = (c <= 7) ? 3'b100 : 3'b001;
         checks++;
         if ({mem_req, done, fault} !== exp_ctl) begin
            errors++;
            $display("FAIL timeout_c%0d: req/done/fault=%b expected %b", c, {mem_req, done, fault}, exp_ctl);
         end
         if (c == 8) begin
            checks++;
            if (fault_cause !== FC_TIMEOUT || fault_addr !== 32'h0000_2000) begin
               errors++;
               $display("FAIL timeout_cause: cause=%b faddr=%h expected 11 00002000", fault_cause, fault_addr);
            end
         end
         tick();
      end
      start(3'd0, SZ_WORD, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         exp_ctl = (c <= 7) ? 3'b100 : 3'b010;
         checks++;
         if ({mem_req, done, fault} !== exp_ctl) begin
            errors++;
            $display("FAIL late_ack_c%0d: req/done/fault=%b expected %b", c, {mem_req, done, fault}, exp_ctl);
         end
         mem_ack = (c == 7);
         tick();
      end
      mem_ack = 1'b0;
`else
      start(3'd0, SZ_WORD, 1'b0);
      for (int c = 1; c <= 21; c++) begin
         exp_ctl = (c <= 20) ? 3'b100 : 3'b010;
         checks++;
         if ({mem_req, done, fault} !== exp_ctl) begin
            errors++;
            $display("FAIL no_timeout_c%0d: req/done/fault=%b expected %b", c, {mem_req, done, fault}, exp_ctl);
         end
         mem_ack = (c == 20);
         tick();
      end
      mem_ack = 1'b0;
`endif
   endtask

   task automatic test_interference();
      logic [1:0] cause_before;
      start(3'd3, SZ_WORD, 1'b1);
      req  = 1'b1;
      sel  = 3'd0;
      size = SZ_BYTE;
      wr   = 1'b0;
      set_src(3, 32'h0000_4444);
      tick();
      req = 1'b0;
      checks++;
      if ({mem_req, done, fault} !== 3'b100 || mem_addr !== 32'h0000_3000 || mem_wr !== 1'b1) begin
         errors++;
         $display("FAIL frozen: req/done/fault=%b addr=%h wr=%b expected 100 00003000 1",
                  {mem_req, done, fault}, mem_addr, mem_wr);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, done, fault} !== 3'b010 || mem_addr !== 32'h0000_3000) begin
         errors++;
         $display("FAIL frozen_done: req/done/fault=%b addr=%h expected 010 00003000",
                  {mem_req, done, fault}, mem_addr);
      end
      sel = 3'd3;
      req = 1'b1;
      tick();
      req = 1'b0;
      for (int c = 0; c < 2; c++) begin
         checks++;
         if ({mem_req, done, fault} !== 3'b000) begin
            errors++;
            $display("FAIL req_in_resp_%0d: req/done/fault=%b expected 000", c, {mem_req, done, fault});
         end
         tick();
      end
      cause_before = fault_cause;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, done, fault} !== 3'b000 || mem_addr !== 32'h0000_3000 || fault_cause !== cause_before) begin
         errors++;
         $display("FAIL ack_in_idle: req/done/fault=%b addr=%h cause=%b expected 000 00003000 %b",
                  {mem_req, done, fault}, mem_addr, fault_cause, cause_before);
      end
      set_src(3, 32'h0000_3000);
      mem_ack = 1'b1;
      start(3'd3, SZ_WORD, 1'b0);
      mem_ack = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         checks++;
         if ({mem_req, done, fault} !== ((c <= 2) ? 3'b100 : 3'b010)) begin
            errors++;
            $display("FAIL req_with_ack_c%0d: req/done/fault=%b expected %b",
                     c, {mem_req, done, fault}, (c <= 2) ? 3'b100 : 3'b010);
         end
         mem_ack = (c == 2);
         tick();
      end
      mem_ack = 1'b0;
   endtask

   // Requests three cycles apart: ack in cycle 1, done in 2, idle in 3, next req sampled in 3.
   task automatic test_back_to_back();
      start(3'd0, SZ_WORD, 1'b0);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, done, fault} !== 3'b010 || mem_addr !== 32'h0000_2000) begin
         errors++;
         $display("FAIL b2b_first_done: req/done/fault=%b addr=%h expected 010 00002000",
                  {mem_req, done, fault}, mem_addr);
      end
      tick();
      start(3'd4, SZ_BYTE, 1'b1);
      checks++;
      if ({mem_req, done, fault} !== 3'b100 || mem_addr !== 32'h0000_1003 || mem_wr !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: req/done/fault=%b addr=%h wr=%b expected 100 00001003 1",
                  {mem_req, done, fault}, mem_addr, mem_wr);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      start(3'd2, SZ_WORD, 1'b1);
      tick();
      reset_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, done, fault, mem_wr} !== 4'b0000 || mem_addr !== '0) begin
         errors++;
         $display("FAIL reset_mid: req/done/fault/wr=%b addr=%h expected 0000 00000000",
                  {mem_req, done, fault, mem_wr}, mem_addr);
      end
      #1 reset_n = 1'b1;
      mem_ack = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if ({mem_req, done, fault} !== 3'b000) begin
            errors++;
            $display("FAIL late_ack_%0d: req/done/fault=%b expected 000", c, {mem_req, done, fault});
         end
      end
      mem_ack = 1'b0;
      start(3'd2, SZ_WORD, 1'b0);
      checks++;
      if ({mem_req, done, fault} !== 3'b100 || mem_addr !== 32'h0000_1004) begin
         errors++;
         $display("FAIL after_reset_req: req/done/fault=%b addr=%h expected 100 00001004",
                  {mem_req, done, fault}, mem_addr);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, done, fault} !== 3'b010) begin
         errors++;
         $display("FAIL after_reset_done: req/done/fault=%b expected 010", {mem_req, done, fault});
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_align();
      test_bad_sel();
      test_timeout();
      test_interference();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
